// File: rtl/xnor_bist_checker.sv
// rtl/xnor_bist_checker.sv - built-in self-test stimulus generator and checker for an N-bit XNOR gate
//
// Walks vector index k from 0 to NUM_VECTORS-1 and drives {dut_a, dut_b} = k.
// Each vector gets one cycle to settle, then the returned dut_f is compared
// against ~(dut_a ^ dut_b). Mismatches are counted and the first failing index
// is recorded. A one-cycle done pulse and a pass flag close the run.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   start           run request, honoured only while idle
//   dut_f           F returned by the gate under test
//   dut_a, dut_b    registered operands to the gate under test
//   busy            high while a run is in progress
//   done            one-cycle end-of-run pulse
//   pass            last completed run had zero mismatches
//   err_count       mismatch count of the last or current run
//   first_fail_idx  index of the first mismatching vector, 0 if none
module xnor_bist_checker #(
  parameter int N           = 4,
  parameter int NUM_VECTORS = 2 ** (2 * N),
  localparam int CW         = $clog2(NUM_VECTORS + 1),
  localparam int IW         = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  dut_f,
  output logic [N-1:0]  dut_a,
  output logic [N-1:0]  dut_b,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [IW-1:0] first_fail_idx
);

  localparam int VW = 2 * N;

  generate
    if (NUM_VECTORS < 1 || NUM_VECTORS > 2 ** (2 * N)) begin : g_bad_num_vectors
      $error("xnor_bist_checker: NUM_VECTORS must be in 1 .. 2**(2*N)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   k;
  logic [N-1:0]    exp_f;
  logic            mismatch;
  logic [CW-1:0]   err_next;
  logic            last_vec;

  assign exp_f    = ~(dut_a ^ dut_b);
  // Case inequality so an X/Z bit on dut_f is flagged in simulation;
  // synthesizes to an ordinary inequality.
  assign mismatch = (dut_f !== exp_f);
  assign err_next = err_count + CW'(mismatch);
  assign last_vec = (k == IW'(NUM_VECTORS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      dut_a          <= '0;
      dut_b          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      k              <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dut_a          <= '0;
            dut_b          <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            k              <= '0;
            busy           <= 1'b1;
            state          <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_next;
            if (err_count == '0) begin
              first_fail_idx <= k;
            end
          end
          if (last_vec) begin
            // pass must include the verdict on the final vector, hence err_next
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            // The operand pair is itself the 2N-bit vector value, so it is
            // simply incremented alongside k.
            k              <= k + IW'(1);
            {dut_a, dut_b} <= {dut_a, dut_b} + VW'(1);
            state          <= S_SETTLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
